first_counter: RTL and testbench



---
 rtl/first_counter_pkg.sv | 13 +
 rtl/first_counter.sv | 52 +++++
 tb/tb_first_counter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/first_counter_pkg.sv
//------------------------------------------------------------------------------
// first_counter_pkg : shared constants for the first_counter counting cell
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package first_counter_pkg;

    localparam int unsigned FC_DEFAULT_WIDTH = 4;

endpackage : first_counter_pkg

`default_nettype wire

// File: rtl/first_counter.sv
//------------------------------------------------------------------------------
// first_counter : enabled up-counter with a registered, glitch-free wrap pulse
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module first_counter
    import first_counter_pkg::*;
#(
    parameter int unsigned WIDTH = FC_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] counter_out,
    output logic             carry_out
);

    localparam logic [WIDTH-1:0] C_COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] C_COUNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             carry_q;
    logic             carry_d;

    // Carry is recomputed every edge, so it drops back to 0 one period after a wrap.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (enable) begin
            count_d = count_q + C_COUNT_ONE;
            carry_d = (count_q == C_COUNT_MAX);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
        end
    end

    assign counter_out = count_q;
    assign carry_out   = carry_q;

endmodule : first_counter

`default_nettype wire

// File: tb/tb_first_counter.sv
//------------------------------------------------------------------------------
// tb_first_counter : directed self-checking bench for first_counter and a cascade
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_first_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic       carry;

    logic       c_rst;
    logic       c_en;
    logic [3:0] c0_cnt;
    logic       c0_carry;
    logic [3:0] c1_cnt;
    logic       c1_carry;

    int checks   = 0;
    int failures = 0;
    int c0_pulses;
    int c1_pulses;

    first_counter #(.WIDTH(4)) u_dut (
        .clock       (clk),
        .reset       (rst),
        .enable      (en),
        .counter_out (cnt),
        .carry_out   (carry)
    );

    first_counter #(.WIDTH(4)) u_casc0 (
        .clock       (clk),
        .reset       (c_rst),
        .enable      (c_en),
        .counter_out (c0_cnt),
        .carry_out   (c0_carry)
    );

    first_counter #(.WIDTH(4)) u_casc1 (
        .clock       (c0_carry),
        .reset       (c_rst),
        .enable      (c_en),
        .counter_out (c1_cnt),
        .carry_out   (c1_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge c0_carry or posedge c_rst) begin
        if (c_rst) c0_pulses <= 0;
        else       c0_pulses <= c0_pulses + 1;
    end

    always @(posedge c1_carry or posedge c_rst) begin
        if (c_rst) c1_pulses <= 0;
        else       c1_pulses <= c1_pulses + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        c_rst = 1'b1;
        c_en  = 1'b0;
        step(2);
        check_value("reset_count", 32'(cnt), 0);
        check_value("reset_carry", 32'(carry), 0);
        rst = 1'b0;

        // Count and hold
        en = 1'b1;
        step(5);
        check_value("count5", 32'(cnt), 5);
        check_value("count5_carry", 32'(carry), 0);
        en = 1'b0;
        step(3);
        check_value("hold5", 32'(cnt), 5);
        check_value("hold5_carry", 32'(carry), 0);

        // Async reset between edges at count 9
        en = 1'b1;
        step(4);
        check_value("count9", 32'(cnt), 9);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_rst_count", 32'(cnt), 0);
        check_value("async_rst_carry", 32'(carry), 0);
        step(2);
        check_value("rst_held_count", 32'(cnt), 0);
        check_value("rst_held_carry", 32'(carry), 0);
        rst = 1'b0;

        // Wrap and carry over 16 enabled edges from 0
        for (int i = 1; i <= 15; i++) begin
            step(1);
            check_value("wrap_seq_count", 32'(cnt), 32'(i));
            check_value("wrap_seq_carry", 32'(carry), 0);
        end
        step(1);
        check_value("wrap_count", 32'(cnt), 0);
        check_value("wrap_carry", 32'(carry), 1);
        step(1);
        check_value("post_wrap_count", 32'(cnt), 1);
        check_value("post_wrap_carry", 32'(carry), 0);

        // No wrap without enable at 15
        step(14);
        check_value("at15_count", 32'(cnt), 15);
        en = 1'b0;
        step(2);
        check_value("nowrap_count", 32'(cnt), 15);
        check_value("nowrap_carry", 32'(carry), 0);
        en = 1'b1;
        step(1);
        check_value("rewrap_count", 32'(cnt), 0);
        check_value("rewrap_carry", 32'(carry), 1);
        step(1);
        check_value("rewrap_fall_count", 32'(cnt), 1);
        check_value("rewrap_fall_carry", 32'(carry), 0);

        // Reset in the middle of a carry pulse
        step(15);
        check_value("pulse_carry", 32'(carry), 1);
        #2;
        rst = 1'b1;
        #1;
        check_value("midpulse_carry", 32'(carry), 0);
        check_value("midpulse_count", 32'(cnt), 0);
        step(1);
        rst = 1'b0;
        step(15);
        check_value("after_rst_15_count", 32'(cnt), 15);
        check_value("after_rst_15_carry", 32'(carry), 0);
        step(1);
        check_value("after_rst_16_count", 32'(cnt), 0);
        check_value("after_rst_16_carry", 32'(carry), 1);

        // Cascade: 450 enabled edges -> 28 wraps, 450 mod 16 = 2, 28 mod 16 = 12
        c_rst = 1'b0;
        c_en  = 1'b1;
        step(450);
        c_en = 1'b0;
        step(1);
        check_value("casc0_count", 32'(c0_cnt), 2);
        check_value("casc0_pulses", 32'(c0_pulses), 28);
        check_value("casc1_count", 32'(c1_cnt), 12);
        check_value("casc1_pulses", 32'(c1_pulses), 1);
        check_value("casc1_carry", 32'(c1_carry), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_first_counter

`default_nettype wire
